// File: rtl/bloque_ultrasonido.sv
// Ultrasonic ranger controller: fires a trigger pulse, times the echo and reports distance in cm.
// Latency: DONE rises 3 clocks after ECHO falls (2-flop sync + edge detect + output register).
// Backpressure: four-phase handshake; a result is held in FINISH until orden is released.
module bloque_ultrasonido #(
    parameter int TRIG_CYCLES    = 1000,
    parameter int CM_CYCLES      = 5800,
    parameter int TIMEOUT_CYCLES = 3800000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       orden,
    input  logic       ECHO,
    output logic       trigg,
    output logic       DONE,
    output logic [7:0] d
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(CM_CYCLES + 1);

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(CM_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        FINISH
    } state_t;

    state_t        state, state_nxt;
    logic          echo_m, echo_s, echo_p;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [7:0]    cm, cm_nxt;
    logic [7:0]    d_nxt;

    logic          echo_rise, echo_fall, wrap;
    logic [7:0]    cm_step, cm_now;

    assign echo_rise = echo_s & ~echo_p;
    assign echo_fall = ~echo_s & echo_p;
    assign wrap      = (presc == PRE_LAST);
    assign cm_step   = (cm == 8'hFF) ? cm : cm + 8'd1;
    // Count the current clock too, so an echo of exactly N*CM_CYCLES clocks reads N.
    assign cm_now    = wrap ? cm_step : cm;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        presc_nxt = presc;
        cm_nxt    = cm;
        d_nxt     = d;
        case (state)
            IDLE: begin
                if (orden == 1'b1) begin
                    state_nxt = TRIG;
                    cnt_nxt   = '0;
                    presc_nxt = '0;
                    cm_nxt    = '0;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_nxt = WAIT_ECHO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_ECHO: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == TO_LAST) begin
                    state_nxt = FINISH;
                    d_nxt     = 8'hFF;
                end else if (echo_rise) begin
                    state_nxt = MEASURE;
                    presc_nxt = '0;
                    cm_nxt    = '0;
                end
            end
            MEASURE: begin
                cnt_nxt   = cnt + CW'(1);
                presc_nxt = wrap ? '0 : presc + PW'(1);
                cm_nxt    = cm_now;
                if (echo_fall) begin
                    state_nxt = FINISH;
                    d_nxt     = cm_now;
                end else if (cnt == TO_LAST) begin
                    state_nxt = FINISH;
                    d_nxt     = 8'hFF;
                end
            end
            FINISH: begin
                if (orden == 1'b0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_p <= 1'b0;
            cnt    <= '0;
            presc  <= '0;
            cm     <= '0;
            trigg  <= 1'b0;
            DONE   <= 1'b0;
            d      <= 8'd0;
        end else begin
            echo_m <= ECHO;
            echo_s <= echo_m;
            echo_p <= echo_s;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            presc  <= presc_nxt;
            cm     <= cm_nxt;
            d      <= d_nxt;
            // Outputs registered from the next state so they line up with the state register.
            trigg  <= (state_nxt == TRIG);
            DONE   <= (state_nxt == FINISH);
        end
    end

endmodule

// File: tb/tb_bloque_ultrasonido.sv
// Directed bench for bloque_ultrasonido with shortened cm and timeout constants.
module tb_bloque_ultrasonido;

    localparam int TRIG = 1000;
    localparam int CM   = 58;
    localparam int TO   = 20000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       orden;
    logic       ECHO;
    logic       trigg;
    logic       DONE;
    logic [7:0] d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bloque_ultrasonido #(
        .TRIG_CYCLES   (TRIG),
        .CM_CYCLES     (CM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .orden(orden),
        .ECHO (ECHO),
        .trigg(trigg),
        .DONE (DONE),
        .d    (d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raise orden and measure the trigger pulse; returns just after trigg falls.
    task automatic start_meas(input string tag);
        int   width;
        logic done_seen;
        width     = 0;
        done_seen = 1'b0;
        @(negedge clk);
        orden = 1'b1;
        tick;
        chk({tag, "_start"}, 32'(trigg), 32'd1);
        while (trigg === 1'b1 && width < 3 * TRIG) begin
            if (DONE !== 1'b0) done_seen = 1'b1;
            width++;
            tick;
        end
        chk({tag, "_width"}, 32'(width), 32'(TRIG));
        chk({tag, "_done_low"}, 32'(done_seen), 32'd0);
    endtask

    // Echo high for exactly n sampling edges, then check result latency and value.
    task automatic measure(input string tag, input int n, input logic [7:0] exp_d, input logic [7:0] prev_d);
        @(negedge clk);
        ECHO = 1'b1;
        repeat (n) @(negedge clk);
        ECHO = 1'b0;
        chk({tag, "_d_held"}, 32'(d), 32'(prev_d));
        tick;
        tick;
        chk({tag, "_done_early"}, 32'(DONE), 32'd0);
        tick;
        chk({tag, "_done"}, 32'(DONE), 32'd1);
        chk({tag, "_d"}, 32'(d), 32'(exp_d));
    endtask

    task automatic finish_hs(input string tag, input logic [7:0] exp_d);
        @(negedge clk);
        orden = 1'b0;
        tick;
        chk({tag, "_done_clr"}, 32'(DONE), 32'd0);
        chk({tag, "_d_keep"}, 32'(d), 32'(exp_d));
    endtask

    initial begin
        logic bad;
        rst_n = 1'b0;
        orden = 1'b0;
        ECHO  = 1'b0;
        repeat (3) tick;
        chk("rst_trigg", 32'(trigg), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_d", 32'(d), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick;
        chk("idle_trigg", 32'(trigg), 32'd0);

        // 250 clocks / 58 -> 4 cm
        start_meas("t1");
        measure("m4", 250, 8'd4, 8'd0);
        finish_hs("h4", 8'd4);
        repeat (5) tick;
        chk("idle_after_h4", 32'(trigg), 32'd0);

        // No echo: timeout lands exactly TO clocks after trigg falls
        start_meas("t2");
        repeat (TO - 1) tick;
        chk("to_early_done", 32'(DONE), 32'd0);
        chk("to_early_d", 32'(d), 32'd4);
        tick;
        chk("to_done", 32'(DONE), 32'd1);
        chk("to_d", 32'(d), 32'd255);
        bad = 1'b0;
        repeat (50) begin
            tick;
            if (trigg !== 1'b0) bad = 1'b1;
        end
        chk("to_no_retrig", 32'(bad), 32'd0);
        chk("to_done_hold", 32'(DONE), 32'd1);
        finish_hs("hto", 8'd255);

        // Reset in the middle of a measurement
        start_meas("t3");
        @(negedge clk);
        ECHO = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        orden = 1'b0;
        tick;
        chk("mrst_trigg", 32'(trigg), 32'd0);
        chk("mrst_done", 32'(DONE), 32'd0);
        chk("mrst_d", 32'(d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ECHO  = 1'b0;
        repeat (5) tick;
        chk("mrst_idle_trigg", 32'(trigg), 32'd0);
        chk("mrst_idle_done", 32'(DONE), 32'd0);

        // Echo already high before the trigger must be ignored; 116 clocks -> exactly 2 cm
        @(negedge clk);
        ECHO = 1'b1;
        repeat (5) tick;
        start_meas("t4");
        repeat (30) tick;
        chk("pre_echo_ignored", 32'(DONE), 32'd0);
        @(negedge clk);
        ECHO = 1'b0;
        repeat (10) @(negedge clk);
        measure("m2", 116, 8'd2, 8'd0);
        finish_hs("h2", 8'd2);

        // One clock short of 2 cm
        start_meas("t5");
        measure("m1", 115, 8'd1, 8'd2);
        finish_hs("h1", 8'd1);

        // 300 cm worth of echo saturates at 255
        start_meas("t6");
        measure("msat", CM * 300, 8'd255, 8'd1);
        finish_hs("hsat", 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bloque_ultrasonido.md
BLOQUE_ULTRASONIDO -- requirements
Module: bloque_ultrasonido

Interface
REQ-001 Parameter TRIG_CYCLES, default 1000: trigger pulse width in clocks (10 us at 100 MHz).
REQ-002 Parameter CM_CYCLES, default 5800: echo clocks per centimetre (58 us at 100 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 3800000: maximum clocks spent waiting for or measuring an echo (38 ms).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-low.
REQ-006 orden  input  1  measurement request, level-sensitive, four-phase handshake with DONE.
REQ-007 ECHO  input  1  sensor echo pulse, asynchronous.
REQ-008 trigg  output  1  sensor trigger pulse, registered.
REQ-009 DONE  output  1  measurement-complete flag, registered.
REQ-010 d  output  8  measured distance in cm, unsigned, registered.

Function
REQ-011 ECHO SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (echo_s) and its previous sample.
REQ-012 FSM states SHALL be IDLE, TRIG, WAIT_ECHO, MEASURE, FINISH.
REQ-013 IDLE: trigg=0, DONE=0; when orden==1 go to TRIG next cycle and clear all counters; orden==0 or X stays in IDLE.
REQ-014 TRIG: trigg SHALL be 1 for exactly TRIG_CYCLES consecutive clocks, then go to WAIT_ECHO with trigg=0.
REQ-015 WAIT_ECHO: on an echo_s rising edge (previous sample 0, current 1), go to MEASURE; an echo_s already high on entry SHALL be ignored until it falls and rises again.
REQ-016 MEASURE: a prescaler SHALL count clocks 0..CM_CYCLES-1 and increment an 8-bit cm counter at each wrap.
REQ-017 The cm counter SHALL saturate at 255, never wrap.
REQ-018 MEASURE: on an echo_s falling edge, d SHALL load the cm counter (floor of echo_clocks/CM_CYCLES), then go to FINISH.
REQ-019 A timeout counter SHALL run from WAIT_ECHO entry through MEASURE; on reaching TIMEOUT_CYCLES, d SHALL load 255 and the FSM goes to FINISH.
REQ-020 FINISH: DONE=1 and d held stable; when orden==0 go to IDLE, where DONE drops to 0 and d keeps its value.
REQ-021 orden deasserted mid-measurement SHALL NOT abort; the measurement completes and FINISH exits immediately on orden==0.
REQ-022 d SHALL change only on the FINISH-entry cycle or at reset.
REQ-023 Counters SHALL be wide enough for TIMEOUT_CYCLES (22 bits at default).

Reset
REQ-024 With rst_n==0 at a clk edge: state=IDLE, trigg=0, DONE=0, d=8'd0, all counters and synchronizer flops cleared.
REQ-025 Reset SHALL take priority in every state, including mid-TRIG and mid-MEASURE; no residual trigg pulse after release.

Verification
REQ-026 Reset, then orden=1 -> trigg high exactly 1000 clocks starting 1 clock after orden is sampled, DONE=0 throughout.
REQ-027 After trigger, ECHO high for 25000 clocks then low -> d=4, DONE=1 about 3 clocks after ECHO falls; orden=0 -> DONE=0 next clock, d stays 4.
REQ-028 ECHO high for 5800*300 clocks -> d=255 (saturation), DONE=1.
REQ-029 ECHO never rises after trigger -> after TIMEOUT_CYCLES, d=255, DONE=1; trigg not re-pulsed while orden stays 1.
REQ-030 rst_n=0 for 1 clock during MEASURE -> next cycle trigg=0, DONE=0, d=0, state IDLE; new orden=1 starts a fresh trigger.
REQ-031 ECHO held high from before TRIG, then falls and rises for 11600 clocks -> d=2.
